fft_magnitude: RTL and testbench
================================

FFT_MAGNITUDE -- requirements
Module: fft_magnitude

Interface
REQ-001 SHALL have parameter width, default 16, giving the real/imag component bit width of one FFT bin.
REQ-002 SHALL have parameter N_2, default 5, giving log2 of FFT point count N; N/2 bins are streamed.
REQ-003 SHALL have ports: clk in 1 (sole clock, rising edge); reset in 1 (asynchronous, active-high).
REQ-004 SHALL have port done in 1: FFT-complete level; RAM contents are valid while high.
REQ-005 SHALL have port rdadr out N_2: bin read address to the FFT result RAM.
REQ-006 SHALL have port rd in 2*width: bin data {re, im}, signed two's complement, valid combinationally in the same cycle as rdadr.
REQ-007 SHALL have ports mag out width (unsigned magnitude), mag_idx out N_2-1 (bin index of mag), mag_valid out 1, mag_last out 1, mag_ready in 1.
REQ-008 SHALL have port busy out 1: high while a frame is in progress.
REQ-009 SHALL have ports peak_bin out N_2-1 and peak_mag out width (see Configuration).

Function
REQ-010 SHALL use FSM states IDLE, RUN, DRAIN.
REQ-011 SHALL register done into done_q each cycle; a start event is done=1 and done_q=0 at a clock edge in IDLE, which moves the FSM to RUN with bin counter idx=0.
REQ-012 SHALL drive rdadr = idx, zero-extended, in RUN; rdadr = 0 in IDLE and DRAIN.
REQ-013 SHALL, in RUN, capture when mag_valid=0 or mag_ready=1: mag <= f(rd), mag_idx <= idx, mag_valid <= 1, idx <= idx+1.
REQ-014 SHALL compute f as max(|re|,|im|) + (min(|re|,|im|) >> 1); |x| is width-bit unsigned; |-2^(width-1)| = 2^(width-1); the result is exact in width bits with no saturation.
REQ-015 SHALL produce first mag_valid one edge after the RUN entry edge, so latency from the start-event edge is 1 cycle; throughput is 1 bin per cycle when mag_ready=1.
REQ-016 SHALL hold mag, mag_idx, mag_last, rdadr and idx stable while mag_valid=1 and mag_ready=0.
REQ-017 SHALL assert mag_last with the capture of bin N/2-1 and move to DRAIN on that edge.
REQ-018 SHALL, in DRAIN, clear mag_valid and mag_last and return to IDLE on the edge where mag_ready=1.
REQ-019 SHALL assert busy in RUN and DRAIN only.
REQ-020 SHALL ignore done falling mid-frame and further start events while not IDLE; the frame completes normally.
REQ-021 SHALL accept a start event in the same cycle DRAIN exits only at the following IDLE edge; an edge missed while busy is not queued.

Reset
REQ-022 SHALL, on reset assertion at any time including mid-frame, immediately force state IDLE, idx=0, done_q=0, rdadr=0, mag=0, mag_idx=0, mag_valid=0, mag_last=0, busy=0, peak_bin=0, peak_mag=0.
REQ-023 SHALL treat done already high at reset release as a start event on the first edge, since done_q=0.

Configuration
REQ-024 SHALL compile peak tracking in when macro FFT_MAG_PEAK_EN is defined: running max over the captured bins of a frame, strictly greater wins, so the lowest index wins ties, with bin 0 (DC) excluded.
REQ-025 SHALL update peak_bin/peak_mag once per frame, on the DRAIN-exit edge, and hold them until the next frame completes.
REQ-026 SHALL tie peak_bin and peak_mag to 0 and build no comparator logic when FFT_MAG_PEAK_EN is undefined.

Verification
REQ-027 SHALL pass: N_2=5, bin0 {re=3, im=-4}, mag_ready=1, pulse done -> bin0 mag=5, mag_idx=0, 1 cycle after start edge; 16 consecutive valid cycles; mag_last with mag_idx=15.
REQ-028 SHALL pass: bin {re=-32768, im=0} -> mag=32768; bin {re=-32768, im=-32768} -> mag=49152.
REQ-029 SHALL pass: mag_ready low for 5 cycles at mag_idx=3 -> mag, mag_idx and rdadr are stable; no bin is skipped or duplicated after release.
REQ-030 SHALL pass: reset asserted at mag_idx=7 -> all outputs 0 asynchronously; the next done rise restarts at mag_idx=0.
REQ-031 SHALL pass: done toggled low then high mid-frame -> frame unaffected, no restart, exactly 16 outputs.
REQ-032 SHALL pass, with FFT_MAG_PEAK_EN: bin0=100, bin5=40, bin9=40, others 0 -> peak_bin=5, peak_mag=40 after DRAIN exit; without the macro, both read 0.

Source files
------------

// File: rtl/fft_magnitude.sv
// Streams the lower N/2 bins of an FFT result RAM as approximate magnitudes, max + min/2, with a ready/valid handshake.
// Optional peak tracking is built only when FFT_MAG_PEAK_EN is defined.
module fft_magnitude #(
  parameter int width = 16,
  parameter int N_2   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 done,
  output logic [N_2-1:0]       rdadr,
  input  logic [2*width-1:0]   rd,
  output logic [width-1:0]     mag,
  output logic [N_2-2:0]       mag_idx,
  output logic                 mag_valid,
  output logic                 mag_last,
  input  logic                 mag_ready,
  output logic                 busy,
  output logic [N_2-2:0]       peak_bin,
  output logic [width-1:0]     peak_mag
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [N_2-2:0] LAST_IDX = '1;

  state_t          state_reg;
  logic [N_2-2:0]  idx_reg;
  logic            done_q;
  logic [width-1:0] re_u, im_u, abs_re, abs_im, max_abs, min_abs, mag_next;
  logic            start, capture, drain_exit;

  assign re_u = rd[2*width-1:width];
  assign im_u = rd[width-1:0];

  // Two's complement negate in width bits; the most negative value maps to 2^(width-1) unsigned.
  assign abs_re  = re_u[width-1] ? (~re_u + 1'b1) : re_u;
  assign abs_im  = im_u[width-1] ? (~im_u + 1'b1) : im_u;
  assign max_abs = (abs_re > abs_im) ? abs_re : abs_im;
  assign min_abs = (abs_re > abs_im) ? abs_im : abs_re;
  assign mag_next = max_abs + (min_abs >> 1);

  assign start      = (state_reg == IDLE) && done && !done_q;
  assign capture    = (state_reg == RUN) && (!mag_valid || mag_ready);
  assign drain_exit = (state_reg == DRAIN) && mag_ready;

  assign rdadr = (state_reg == RUN) ? {1'b0, idx_reg} : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      done_q    <= 1'b0;
      mag       <= '0;
      mag_idx   <= '0;
      mag_valid <= 1'b0;
      mag_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done_q <= done;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= RUN;
            idx_reg   <= '0;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          if (capture) begin
            mag       <= mag_next;
            mag_idx   <= idx_reg;
            mag_valid <= 1'b1;
            idx_reg   <= idx_reg + 1'b1;
            if (idx_reg == LAST_IDX) begin
              mag_last  <= 1'b1;
              state_reg <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (drain_exit) begin
            mag_valid <= 1'b0;
            mag_last  <= 1'b0;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef FFT_MAG_PEAK_EN
  logic [N_2-2:0]   run_bin_reg;
  logic [width-1:0] run_mag_reg;

  // Running max excludes DC; strict compare keeps the lowest index on ties.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_bin_reg <= '0;
      run_mag_reg <= '0;
      peak_bin    <= '0;
      peak_mag    <= '0;
    end else begin
      if (start) begin
        run_bin_reg <= '0;
        run_mag_reg <= '0;
      end else if (capture && (idx_reg != '0) && (mag_next > run_mag_reg)) begin
        run_bin_reg <= idx_reg;
        run_mag_reg <= mag_next;
      end
      if (drain_exit) begin
        peak_bin <= run_bin_reg;
        peak_mag <= run_mag_reg;
      end
    end
  end
`else
  assign peak_bin = '0;
  assign peak_mag = '0;
`endif

endmodule

// File: tb/tb_fft_magnitude.sv
// Randomized bench for fft_magnitude: a RAM model feeds rd, a scoreboard checks every handshake against max+min/2.
// Peak expectations follow FFT_MAG_PEAK_EN when it is defined for the build.
module tb_fft_magnitude;

  localparam int W = 16;
  localparam int N2 = 5;
  localparam int BINS = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           done;
  logic [N2-1:0]  rdadr;
  logic [2*W-1:0] rd;
  logic [W-1:0]   mag;
  logic [N2-2:0]  mag_idx;
  logic           mag_valid;
  logic           mag_last;
  logic           mag_ready;
  logic           busy;
  logic [N2-2:0]  peak_bin;
  logic [W-1:0]   peak_mag;

  logic [2*W-1:0] ram [0:31];
  assign rd = ram[rdadr];

  always #5 clk = ~clk;

  fft_magnitude #(.width(W), .N_2(N2)) dut (
    .clk(clk), .reset(reset), .done(done), .rdadr(rdadr), .rd(rd),
    .mag(mag), .mag_idx(mag_idx), .mag_valid(mag_valid), .mag_last(mag_last),
    .mag_ready(mag_ready), .busy(busy), .peak_bin(peak_bin), .peak_mag(peak_mag)
  );

  int n_tests = 0;
  int n_fail = 0;
  int exp_idx = 0;
  int got = 0;
  bit mon_en = 0;
  int exp_peak_bin = 0;
  int exp_peak_mag = 0;

  bit   prev_hold = 0;
  int   prev_mag, prev_idx, prev_last, prev_adr;

  task automatic check_eq(input string tag, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int ref_mag(input logic [2*W-1:0] w);
    int re, im, ar, ai, hi, lo;
    re = int'($signed(w[2*W-1:W]));
    im = int'($signed(w[W-1:0]));
    ar = (re < 0) ? -re : re;
    ai = (im < 0) ? -im : im;
    hi = (ar > ai) ? ar : ai;
    lo = (ar > ai) ? ai : ar;
    return hi + lo / 2;
  endfunction

  function automatic logic [W-1:0] rand_comp();
    logic [W-1:0] v;
    v = W'($urandom);
    if ($urandom_range(0, 7) == 0) v = 16'h8000;
    return v;
  endfunction

  // Scoreboard: a handshake seen here completes on the next rising edge.
  always @(negedge clk) begin
    if (reset || !mon_en) begin
      prev_hold = 0;
    end else begin
      if (prev_hold) begin
        check_eq("hold_mag", int'(mag), prev_mag);
        check_eq("hold_idx", int'(mag_idx), prev_idx);
        check_eq("hold_last", int'(mag_last), prev_last);
        check_eq("hold_rdadr", int'(rdadr), prev_adr);
      end
      if (mag_valid && mag_ready) begin
        $display("[TB] bin %0d mag %0d last %0b", mag_idx, mag, mag_last);
        check_eq("mag", int'(mag), ref_mag(ram[exp_idx & 31]));
        check_eq("mag_idx", int'(mag_idx), exp_idx);
        check_eq("mag_last", int'(mag_last), (exp_idx == BINS - 1) ? 1 : 0);
        exp_idx++;
        got++;
      end
      prev_hold = mag_valid && !mag_ready;
      prev_mag  = int'(mag);
      prev_idx  = int'(mag_idx);
      prev_last = int'(mag_last);
      prev_adr  = int'(rdadr);
    end
  end

  task automatic fill_ram(input int mode);
    for (int i = 0; i < 32; i++) ram[i] = {rand_comp(), rand_comp()};
    case (mode)
      0: ram[0] = {16'h0003, 16'hFFFC};
      1: begin
        ram[1] = {16'h8000, 16'h0000};
        ram[2] = {16'h8000, 16'h8000};
        ram[3] = {16'h7FFF, 16'h8000};
      end
      5: begin
        for (int i = 0; i < 32; i++) ram[i] = '0;
        ram[0] = {16'd100, 16'd0};
        ram[5] = {16'd40, 16'd0};
        ram[9] = {16'd0, 16'hFFD8};
      end
      default: ;
    endcase
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_mag"}, int'(mag), 0);
    check_eq({tag, "_idx"}, int'(mag_idx), 0);
    check_eq({tag, "_valid"}, int'(mag_valid), 0);
    check_eq({tag, "_last"}, int'(mag_last), 0);
    check_eq({tag, "_busy"}, int'(busy), 0);
    check_eq({tag, "_rdadr"}, int'(rdadr), 0);
    check_eq({tag, "_pbin"}, int'(peak_bin), 0);
    check_eq({tag, "_pmag"}, int'(peak_mag), 0);
  endtask

  // Modes: 0 directed 3/-4, 1 extremes, 2 stall at bin 3, 3 reset at bin 7,
  // 4 done toggled mid-frame, 5 peak table, others fully random.
  task automatic run_frame(input int mode);
    int cyc, vcyc, stalls, pb, pm, m;
    bit aborted;
    fill_ram(mode);
    exp_idx = 0; got = 0; cyc = 0; vcyc = 0; stalls = 0; aborted = 0;
    mag_ready = 1'b1;
    @(posedge clk); #1 done = 1'b1;
    @(posedge clk); #1;
    done = 1'b0;
    check_eq("busy_start", int'(busy), 1);
    check_eq("lat_not_yet", int'(mag_valid), 0);
    check_eq("peak_hold_bin", int'(peak_bin), exp_peak_bin);
    check_eq("peak_hold_mag", int'(peak_mag), exp_peak_mag);
    mon_en = 1;
    while ((got < BINS || busy) && cyc < 200) begin
      case (mode)
        0, 3, 4, 5: mag_ready = 1'b1;
        2: begin
          if (mag_valid && mag_idx == 3 && stalls < 5) begin
            mag_ready = 1'b0;
            stalls++;
          end else begin
            mag_ready = 1'b1;
          end
        end
        default: mag_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (mode == 4) begin
        if (cyc == 4) done = 1'b1;
        if (cyc == 6) done = 1'b0;
        if (cyc == 8) done = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
      if (mag_valid) vcyc++;
      if (cyc == 1) begin
        check_eq("lat_first_valid", int'(mag_valid), 1);
        check_eq("lat_first_idx", int'(mag_idx), 0);
      end
      if (mode == 3 && mag_valid && mag_idx == 7) begin
        reset = 1'b1;
        #2;
        check_reset_outputs("async_rst");
        mon_en = 0;
        @(posedge clk); #2;
        check_reset_outputs("rst_hold");
        reset = 1'b0;
        exp_peak_bin = 0;
        exp_peak_mag = 0;
        aborted = 1;
        break;
      end
    end
    done = 1'b0;
    if (!aborted) begin
      check_eq("frame_timeout", (cyc < 200) ? 1 : 0, 1);
      check_eq("frame_count", got, BINS);
      check_eq("end_busy", int'(busy), 0);
      check_eq("end_valid", int'(mag_valid), 0);
      check_eq("end_rdadr", int'(rdadr), 0);
      if (mode == 0) begin
        check_eq("full_rate_cycles", cyc, BINS + 1);
        check_eq("full_rate_valid", vcyc, BINS);
      end
      if (mode == 2) check_eq("stall_cycles", stalls, 5);
      pb = 0; pm = 0;
      for (int i = 1; i < BINS; i++) begin
        m = ref_mag(ram[i]);
        if (m > pm) begin pm = m; pb = i; end
      end
`ifdef FFT_MAG_PEAK_EN
      exp_peak_bin = pb;
      exp_peak_mag = pm;
`else
      exp_peak_bin = 0;
      exp_peak_mag = 0;
`endif
      check_eq("peak_bin", int'(peak_bin), exp_peak_bin);
      check_eq("peak_mag", int'(peak_mag), exp_peak_mag);
      $display("[TB] frame mode %0d done: %0d bins in %0d cycles, peak %0d@%0d", mode, got, cyc, peak_mag, peak_bin);
    end
    mon_en = 0;
    mag_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    done = 1'b0;
    mag_ready = 1'b0;
    for (int i = 0; i < 32; i++) ram[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    for (int f = 0; f < 12; f++) run_frame(f);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
